neuron_8vs: RTL and testbench
=============================

# neuron_8vs

Eight-input leaky integrate-and-fire neuron used as the basic processing element of the tiny SNN fabric. It synchronises eight event inputs, adds a per-synapse weight to a membrane potential for each event, and applies a multiplicative leak on every rising edge of a slow level-clock input. It emits a spike when the potential reaches a programmable threshold, then clears the potential.

## Interface
- p_width, 8, synapse weight width (W)
- p_resbit, 32, potential headroom/resolution bits (R)
- p_spike_num, 2, width of the spike counter field (S); N = W+R+S+3 is the potential width
- i_base_clk  in  1  sole clock; all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_level_clk  in  1  slow leak strobe, treated as data (synchronised, rising edge = leak tick)
- i_event  in  [8:1]  event inputs, level-sampled, each pulse ≥1 i_base_clk period
- i_weight_1 … i_weight_8  in  W each  unsigned weight of synapse k
- i_threshold  in  N  unsigned firing threshold
- o_syncout  out  [8:1]  one-cycle pulse per synchronised event rising edge
- o_sv  out  N  membrane potential register
- o_neuron_out  out  N  bit0 = fire pulse; bits [S:1] = fire count mod 2^S; other bits 0

## Operation
- Event path, per bit k: 2-flop synchroniser, third flop for edge detect; registered o_syncout[k] = s2 & ~s3.
- Level path: same synchroniser/edge detect on i_level_clk gives internal one-cycle `tick`.
- Input sum = Σ o_syncout[k] ? i_weight_k : 0, zero-extended. Max 8·(2^W−1) fits W+3 bits.
- Potential update each cycle, where V is o_sv:
  - if fire this cycle: V ← sum (no leak);
  - else: L = tick ? V − (V >> LEAK_SHIFT) : V; V ← sat(L + sum).
  - sat clamps to all-ones of N bits.
- Fire: registered fire ← (V ≥ i_threshold), unsigned compare on the current o_sv. The cycle fire is high, the V clear above applies.
- Spike counter: S-bit, increments on each fire and wraps.
- i_threshold = 0: the comparison is always true, so the neuron fires every cycle.
- Multiple events in the same cycle are summed. An event coincident with a tick is added after the leak.

## Timing
- Reset (async assert, synchronous effect on deassert): all synchroniser flops, o_syncout, o_sv, fire, counter = 0. o_neuron_out = 0.
- Event sampled high at edge t0 → o_syncout pulse during t2 → o_sv includes weight at t3 → fire pulse and V clear at t4 if the threshold is met.
- A held-high event produces exactly one o_syncout pulse. It must go low for ≥1 cycle before it can retrigger.
- i_level_clk rising edge sampled at t0 → leak applied to V at t3.
- Reset mid-accumulation discards all state immediately.

## Structure
- Shared package `snn_pkg`:
  - LEAK_SHIFT = 3
  - SYNC_STAGES = 2
  - width function N(W,R,S) = W+R+S+3
- Sub-module `edge_sync`: parameterised synchroniser plus rising-edge pulse. Instantiated 9 times (8 events, 1 level clock).
- Top level holds the adder tree, the leak/saturate datapath, the comparator, the fire register and the counter.

## Test plan
All cases use W=8, R=32, S=2, N=45, all weights 0xFF, threshold 0x3FF, i_level_clk held low unless stated.
- Reset: i_rst_n=0 → all outputs 0; release → still 0 with no events.
- Single event on bit 1 (1 cycle) → o_syncout[1] pulses at t2, o_sv=0xFF at t3, no fire. One level-clock rise → o_sv = 0xFF − 0x1F = 0xE0.
- Simultaneous events 8'b00001111 → o_sv=0x3FC, no fire. Later, event on bit 5 → o_sv=0x4FB, next cycle o_neuron_out=0x3 (fire plus count 1), following cycle o_sv=0 and bit0=0.
- Eight sequential events on bits 1..8, one per 5 cycles, with a level-clock rise every 10 cycles → at least one fire; o_sv never exceeds threshold+0xFF before the clear.
- Threshold 0 → fire every cycle; count field cycles 1,2,3,0; o_sv stays 0.
- Assert reset while o_sv=0x3FC → o_sv, counter and o_syncout return to 0 asynchronously; a pending event is lost.

Source files
------------

// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared constants and helpers for the SNN fabric processing elements.
//   LEAK_SHIFT   : leak removes V >> LEAK_SHIFT from the potential per tick
//   SYNC_STAGES  : flops in each input synchroniser chain
//   NUM_SYN      : synapses per neuron
//   n_width()    : membrane potential width N = W + R + S + 3
// ---------------------------------------------------------------------------
package snn_pkg;

    localparam int LEAK_SHIFT  = 3;
    localparam int SYNC_STAGES = 2;
    localparam int NUM_SYN     = 8;

    // Potential width: W+3 bits hold the worst-case 8-way weight sum, R bits of
    // headroom/resolution above it, S bits matching the spike counter field.
    function automatic int n_width(input int w, input int r, input int s);
        return w + r + s + 3;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// Brings one asynchronous level into the i_clk domain through a p_stages-deep
// synchroniser, keeps one more flop of history, and emits a registered
// one-cycle pulse on every synchronised rising edge. A level held high yields
// exactly one pulse; it must drop for at least one cycle to retrigger.
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   i_din    : asynchronous input level
//   o_pulse  : registered one-cycle pulse per rising edge of i_din
// ---------------------------------------------------------------------------
module edge_sync
    import snn_pkg::*;
#(
    parameter int p_stages = SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_pulse
);

    logic [p_stages-1:0] sync_q;
    logic [p_stages-1:0] sync_d;
    logic                edge_q;
    logic                edge_d;
    logic                pulse_q;
    logic                pulse_d;

    // NOTE: every signal written here gets a value on every path (the shift
    // and compare are unconditional), so no latch can be inferred.
    always_comb begin
        sync_d  = {sync_q[p_stages-2:0], i_din};
        edge_d  = sync_q[p_stages-1];
        pulse_d = sync_q[p_stages-1] & ~edge_q;
    end

    // NOTE: non-blocking assignments let each flop capture its pre-edge input,
    // which is what makes this a real shift chain rather than a wire.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            edge_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            edge_q  <= edge_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/neuron_8vs.sv
// ---------------------------------------------------------------------------
// neuron_8vs
// Eight-input leaky integrate-and-fire neuron.
//   i_base_clk        : sole clock, all state on its rising edge
//   i_rst_n           : asynchronous active-low reset
//   i_level_clk       : slow leak strobe, synchronised; each rise = one leak
//   i_event[8:1]      : event inputs (level-sampled, synchronised)
//   i_weight_1..8     : unsigned per-synapse weights (p_width bits)
//   i_threshold       : unsigned firing threshold (N bits)
//   o_syncout[8:1]    : one-cycle pulse per synchronised event rising edge
//   o_sv              : membrane potential register (N bits)
//   o_neuron_out      : bit0 fire pulse, bits [S:1] fire count mod 2^S
// ---------------------------------------------------------------------------
module neuron_8vs
    import snn_pkg::*;
#(
    parameter  int p_width     = 8,
    parameter  int p_resbit    = 32,
    parameter  int p_spike_num = 2,
    localparam int N           = n_width(p_width, p_resbit, p_spike_num)
) (
    input  logic               i_base_clk,
    input  logic               i_rst_n,
    input  logic               i_level_clk,
    input  logic [8:1]         i_event,
    input  logic [p_width-1:0] i_weight_1,
    input  logic [p_width-1:0] i_weight_2,
    input  logic [p_width-1:0] i_weight_3,
    input  logic [p_width-1:0] i_weight_4,
    input  logic [p_width-1:0] i_weight_5,
    input  logic [p_width-1:0] i_weight_6,
    input  logic [p_width-1:0] i_weight_7,
    input  logic [p_width-1:0] i_weight_8,
    input  logic [N-1:0]       i_threshold,
    output logic [8:1]         o_syncout,
    output logic [N-1:0]       o_sv,
    output logic [N-1:0]       o_neuron_out
);

    // Eight full-scale weights fit in W+3 bits.
    localparam int                     SUM_W   = p_width + 3;
    localparam logic [p_spike_num-1:0] CNT_ONE = p_spike_num'(1);

    logic [p_width-1:0]     weight [1:NUM_SYN];
    logic                   tick;
    logic [SUM_W-1:0]       syn_sum;
    logic [N-1:0]           leak_v;
    logic [N:0]             acc_v;
    logic [N-1:0]           sat_v;
    logic [N-1:0]           cmp_v;

    logic [N-1:0]           sv_q;
    logic [N-1:0]           sv_d;
    logic                   fire_q;
    logic                   fire_d;
    logic [p_spike_num-1:0] cnt_q;
    logic [p_spike_num-1:0] cnt_d;

    assign weight[1] = i_weight_1;
    assign weight[2] = i_weight_2;
    assign weight[3] = i_weight_3;
    assign weight[4] = i_weight_4;
    assign weight[5] = i_weight_5;
    assign weight[6] = i_weight_6;
    assign weight[7] = i_weight_7;
    assign weight[8] = i_weight_8;

    // ---- input synchronisers: one per event, one for the leak strobe -------
    for (genvar k = 1; k <= NUM_SYN; k++) begin : g_evt_sync
        edge_sync #(
            .p_stages (SYNC_STAGES)
        ) u_evt_sync (
            .i_clk   (i_base_clk),
            .i_rst_n (i_rst_n),
            .i_din   (i_event[k]),
            .o_pulse (o_syncout[k])
        );
    end

    edge_sync #(
        .p_stages (SYNC_STAGES)
    ) u_level_sync (
        .i_clk   (i_base_clk),
        .i_rst_n (i_rst_n),
        .i_din   (i_level_clk),
        .o_pulse (tick)
    );

    // ---- weighted input sum of this cycle's synchronised events ------------
    always_comb begin
        syn_sum = '0;
        for (int k = 1; k <= NUM_SYN; k++) begin
            if (o_syncout[k]) begin
                syn_sum = syn_sum + SUM_W'(weight[k]);
            end
        end
    end

    // ---- leak, integrate, saturate, compare ---------------------------------
    always_comb begin
        // Leak is applied before this cycle's input is added.
        leak_v = tick ? (sv_q - (sv_q >> LEAK_SHIFT)) : sv_q;
        acc_v  = {1'b0, leak_v} + (N+1)'(syn_sum);
        sat_v  = acc_v[N] ? '1 : acc_v[N-1:0];

        // While the fire pulse is high the old potential is being discarded,
        // so the next state restarts from just this cycle's input.
        sv_d   = fire_q ? N'(syn_sum) : sat_v;

        // The potential held during a fire cycle has already produced its
        // spike; comparing it again would emit a second spike for the same
        // charge. It is treated as already cleared (zero) for the comparison,
        // which still lets a zero threshold fire on every cycle.
        cmp_v  = fire_q ? '0 : sv_q;
        fire_d = (cmp_v >= i_threshold);

        cnt_d  = fire_d ? (cnt_q + CNT_ONE) : cnt_q;
    end

    always_ff @(posedge i_base_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sv_q   <= '0;
            fire_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sv_q   <= sv_d;
            fire_q <= fire_d;
            cnt_q  <= cnt_d;
        end
    end

    // ---- outputs ------------------------------------------------------------
    always_comb begin
        o_neuron_out                = '0;
        o_neuron_out[0]             = fire_q;
        o_neuron_out[p_spike_num:1] = cnt_q;
    end

    assign o_sv = sv_q;

endmodule

// File: tb/tb_neuron_8vs.sv
// ---------------------------------------------------------------------------
// tb_neuron_8vs
// Self-checking bench for neuron_8vs (W=8, R=32, S=2, N=45). A behavioural
// model tracks the expected outputs from the neuron's rules: inputs reach the
// datapath through a fixed two-cycle synchronisation delay plus a registered
// edge pulse, the potential integrates/leaks/saturates, and a spike clears it.
// Directed scenarios add fixed-value checks; a randomized run follows.
// ---------------------------------------------------------------------------
module tb_neuron_8vs;

    localparam int W = 8;
    localparam int R = 32;
    localparam int S = 2;
    localparam int N = W + R + S + 3;
    localparam logic [63:0] V_MAX = (64'd1 << N) - 64'd1;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           level = 1'b0;
    logic [8:1]     ev    = '0;
    logic [W-1:0]   w [1:8];
    logic [N-1:0]   thr   = '0;
    logic [8:1]     syncout;
    logic [N-1:0]   sv;
    logic [N-1:0]   nout;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [8:0]  h0, h1, h2, h3;   // sampled {level, events}, h0 = newest edge
    logic [8:1]  m_sync;
    logic        m_tick;
    logic        m_fire;
    logic [63:0] m_v;
    logic [1:0]  m_cnt;

    // observations for the sequential-event scenario
    logic [63:0] max_sv;
    logic        saw_fire;

    always #5 clk = ~clk;

    neuron_8vs #(
        .p_width     (W),
        .p_resbit    (R),
        .p_spike_num (S)
    ) dut (
        .i_base_clk   (clk),
        .i_rst_n      (rst_n),
        .i_level_clk  (level),
        .i_event      (ev),
        .i_weight_1   (w[1]),
        .i_weight_2   (w[2]),
        .i_weight_3   (w[3]),
        .i_weight_4   (w[4]),
        .i_weight_5   (w[5]),
        .i_weight_6   (w[6]),
        .i_weight_7   (w[7]),
        .i_weight_8   (w[8]),
        .i_threshold  (thr),
        .o_syncout    (syncout),
        .o_sv         (sv),
        .o_neuron_out (nout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        h0 = '0; h1 = '0; h2 = '0; h3 = '0;
        m_sync = '0; m_tick = 1'b0; m_fire = 1'b0; m_v = '0; m_cnt = '0;
    endtask

    // One rising clock edge of the reference behaviour.
    task automatic model_edge();
        logic [63:0] sum;
        logic [63:0] lv;
        logic [63:0] nv;
        logic        nf;
        logic [8:0]  p;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sum = 64'd0;
        for (int k = 1; k <= 8; k++) begin
            if (m_sync[k]) sum = sum + 64'(w[k]);
        end
        nf = ((m_fire ? 64'd0 : m_v) >= 64'(thr));
        if (m_fire) begin
            nv = sum;
        end else begin
            lv = m_tick ? (m_v - (m_v >> 3)) : m_v;
            nv = (lv + sum > V_MAX) ? V_MAX : (lv + sum);
        end
        h3 = h2; h2 = h1; h1 = h0; h0 = {level, ev};
        p      = h2 & ~h3;
        m_sync = p[7:0];
        m_tick = p[8];
        m_fire = nf;
        m_v    = nv;
        if (nf) m_cnt = m_cnt + 2'd1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("syncout", 64'(syncout), 64'(m_sync));
        check("sv", 64'(sv), m_v);
        check("nout", 64'(nout), {61'd0, m_cnt, m_fire});
        if (64'(sv) > max_sv) max_sv = 64'(sv);
        if (nout[0]) saw_fire = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ev    = '0;
        level = 1'b0;
        #1;
        model_reset();
        check("rst_sv", 64'(sv), 64'd0);
        check("rst_nout", 64'(nout), 64'd0);
        check("rst_sync", 64'(syncout), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 1; k <= 8; k++) w[k] = 8'hFF;
        thr = 45'h3FF;
        max_sv = '0;
        saw_fire = 1'b0;
        model_reset();
        #2;

        // ---- reset, then idle ------------------------------------------------
        do_reset();
        repeat (5) step();
        check("idle_sv", 64'(sv), 64'd0);
        check("idle_nout", 64'(nout), 64'd0);

        // ---- single event on bit 1, then one leak tick --------------------------
        ev = 8'h01; step(); ev = '0;
        step(); step();
        check("single_pulse", 64'(syncout), 64'h01);
        step();
        check("single_sv", 64'(sv), 64'hFF);
        check("single_nofire", 64'(nout), 64'd0);
        level = 1'b1;
        repeat (4) step();
        check("single_leak", 64'(sv), 64'hE0);
        repeat (3) step();
        level = 1'b0;
        repeat (3) step();

        // ---- simultaneous events, then crossing the threshold -------------------
        do_reset();
        ev = 8'h0F; step(); ev = '0;
        repeat (3) step();
        check("multi_sv", 64'(sv), 64'h3FC);
        check("multi_nofire", 64'(nout), 64'd0);
        repeat (2) step();
        ev = 8'h10; step(); ev = '0;
        repeat (3) step();
        check("cross_sv", 64'(sv), 64'h4FB);
        step();
        check("cross_fire", 64'(nout), 64'h3);
        step();
        check("cross_clear", 64'(sv), 64'd0);
        check("cross_bit0", 64'(nout[0]), 64'd0);
        repeat (3) step();

        // ---- eight sequential events with periodic leak -------------------------
        do_reset();
        max_sv   = '0;
        saw_fire = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ev    = (i % 5 == 0 && i / 5 < 8) ? 8'(1 << (i / 5)) : 8'h00;
            level = ((i % 10) >= 5);
            step();
        end
        check("seq_fired", 64'(saw_fire), 64'd1);
        check("seq_bounded", 64'(max_sv <= 64'h3FF + 64'hFF), 64'd1);

        // ---- zero threshold: fire every cycle -----------------------------------
        thr = '0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step();
            check("thr0_out", 64'(nout), 64'((((k + 1) % 4) << 1) | 1));
            check("thr0_sv", 64'(sv), 64'd0);
        end
        thr = 45'h3FF;

        // ---- asynchronous reset mid-accumulation --------------------------------
        do_reset();
        ev = 8'h0F; step(); ev = '0;
        repeat (3) step();
        check("pre_rst_sv", 64'(sv), 64'h3FC);
        ev = 8'h01; step(); ev = '0; step();
        do_reset();
        repeat (6) step();
        check("post_rst_sv", 64'(sv), 64'd0);
        check("post_rst_nout", 64'(nout), 64'd0);

        // ---- randomized traffic -------------------------------------------------
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) thr = 45'($urandom_range(0, 'h1800));
            if ($urandom_range(0, 99) == 0) begin
                for (int k = 1; k <= 8; k++) w[k] = 8'($urandom);
            end
            ev = 8'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) level = ~level;
            if (i == 300) do_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
